// File: rtl/sensor_multi_core.sv
// Sequences CH_NUM ultrasonic rangers: trigger, time the echo width in us, then idle before the next channel.
// One dat_vld per enabled channel, issued the clk_sys cycle after echo fall or timeout; done_measure pulses at sweep end.
// No backpressure: results are single-cycle pulses, and fire/stop requests are ignored when they do not apply.
module sensor_multi_core #(
  parameter int CH_NUM     = 4,
  parameter int CNT_W      = 16,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 30000,
  parameter int GAP_US     = 60000
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              pluse_us,
  input  logic              fire_measure,
  input  logic              stop_measure,
  input  logic              mode,
  input  logic [CH_NUM-1:0] ch_en,
  input  logic [CH_NUM-1:0] echo,
  output logic [CH_NUM-1:0] trig,
  output logic              busy,
  output logic              dat_vld,
  output logic [2:0]        dat_ch,
  output logic [CNT_W-1:0]  dat_val,
  output logic [CH_NUM-1:0] err_measure,
  output logic              done_measure
);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEAS, GAP} state_t;

  localparam logic [31:0]      TRIG_END = 32'(TRIG_US - 1);
  localparam logic [31:0]      RISE_END = 32'(TIMEOUT_US - 1);
  localparam logic [31:0]      GAP_END  = 32'(GAP_US - 1);
  localparam logic [CNT_W-1:0] MEAS_END = CNT_W'(TIMEOUT_US - 1);

  state_t            state, state_nxt;
  logic [2:0]        ch, nxt_ch, first_ch;
  logic              nxt_vld;
  logic [CH_NUM-1:0] mask_q, first_src, ch_oh;
  logic              mode_q, stop_pend, echo_sel;
  logic [31:0]       tmr;
  logic [CNT_W-1:0]  cnt;
  logic              accept, trig_end, rise_to, meas_to, gap_end, restart;

  assign ch_oh    = CH_NUM'(1) << ch;
  assign echo_sel = |(echo & ch_oh);

  // Next channel above the current one, and lowest channel for a fresh sweep.
  always_comb begin
    nxt_vld   = 1'b0;
    nxt_ch    = ch;
    first_ch  = '0;
    first_src = (state == IDLE) ? ch_en : mask_q;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (mask_q[i] && i > int'(ch)) begin
        nxt_vld = 1'b1;
        nxt_ch  = 3'(i);
      end
      if (first_src[i]) first_ch = 3'(i);
    end
  end

  assign accept   = (state == IDLE) && fire_measure && (|ch_en);
  assign trig_end = pluse_us && (tmr == TRIG_END);
  assign rise_to  = pluse_us && (tmr == RISE_END);
  assign meas_to  = pluse_us && (cnt == MEAS_END);
  assign gap_end  = pluse_us && (tmr == GAP_END);
  assign restart  = gap_end && !nxt_vld && mode_q && !stop_pend;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept) state_nxt = TRIG;
      TRIG:      if (trig_end) state_nxt = WAIT_RISE;
      WAIT_RISE: if (echo_sel) state_nxt = MEAS;
                 else if (rise_to) state_nxt = GAP;
      MEAS:      if (!echo_sel || meas_to) state_nxt = GAP;
      GAP:       if (gap_end) state_nxt = (nxt_vld || restart) ? TRIG : IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    trig = (state == TRIG) ? ch_oh : '0;
    busy = (state != IDLE);
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      ch           <= '0;
      mask_q       <= '0;
      mode_q       <= 1'b0;
      stop_pend    <= 1'b0;
      tmr          <= '0;
      cnt          <= '0;
      dat_vld      <= 1'b0;
      dat_ch       <= '0;
      dat_val      <= '0;
      err_measure  <= '0;
      done_measure <= 1'b0;
    end else begin
      dat_vld      <= 1'b0;
      done_measure <= 1'b0;
      // The phase timer restarts on every state change.
      if (state_nxt != state) tmr <= '0;
      else if (pluse_us)      tmr <= tmr + 32'd1;
      if (state != IDLE && stop_measure) stop_pend <= 1'b1;
      case (state)
        IDLE: if (accept) begin
          mask_q      <= ch_en;
          mode_q      <= mode;
          err_measure <= '0;
          ch          <= first_ch;
          stop_pend   <= 1'b0;
        end
        WAIT_RISE: begin
          if (echo_sel) begin
            cnt <= '0;
          end else if (rise_to) begin
            err_measure <= err_measure | ch_oh;
            dat_vld     <= 1'b1;
            dat_ch      <= ch;
            dat_val     <= '1;
          end
        end
        MEAS: begin
          // A tick landing on the falling edge is deliberately not counted.
          if (!echo_sel) begin
            dat_vld <= 1'b1;
            dat_ch  <= ch;
            dat_val <= cnt;
          end else if (meas_to) begin
            err_measure <= err_measure | ch_oh;
            dat_vld     <= 1'b1;
            dat_ch      <= ch;
            dat_val     <= '1;
          end else if (pluse_us) begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: if (gap_end) begin
          if (nxt_vld) begin
            ch <= nxt_ch;
          end else begin
            done_measure <= 1'b1;
            if (restart) begin
              ch          <= first_ch;
              err_measure <= '0;
            end else begin
              stop_pend <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sensor_multi_core.md
SENSOR_MULTI_CORE -- requirements
Module: sensor_multi_core

Interface
REQ-001 Parameter CH_NUM, default 4: number of ultrasonic channels, range 1..8.
REQ-002 Parameter CNT_W, default 16: echo width counter and result width, in us.
REQ-003 Parameter TRIG_US, default 10: trig pulse length, in pluse_us ticks.
REQ-004 Parameter TIMEOUT_US, default 30000: per-channel timeout for echo rise and for echo width; must be less than 2^CNT_W.
REQ-005 Parameter GAP_US, default 60000: idle gap after each channel's measurement, in pluse_us ticks.
REQ-006 clk_sys  in  1  system clock; single clock domain.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 pluse_us  in  1  one-clk_sys-wide pulse, once per microsecond.
REQ-009 fire_measure  in  1  single-cycle start request.
REQ-010 stop_measure  in  1  single-cycle request to end continuous mode.
REQ-011 mode  in  1  0 = single sweep; 1 = continuous sweeps.
REQ-012 ch_en  in  CH_NUM  channel enable mask.
REQ-013 echo  in  CH_NUM  echo inputs, already synchronised to clk_sys.
REQ-014 trig  out  CH_NUM  trigger outputs.
REQ-015 busy  out  1  high from the cycle after an accepted fire until return to IDLE.
REQ-016 dat_vld  out  1  one-cycle pulse per finished channel.
REQ-017 dat_ch  out  3  channel index qualified by dat_vld.
REQ-018 dat_val  out  CNT_W  echo width in us, qualified by dat_vld.
REQ-019 err_measure  out  CH_NUM  sticky per-channel error flags for the current sweep.
REQ-020 done_measure  out  1  one-cycle pulse at the end of each sweep.

Function
REQ-021 FSM states SHALL be IDLE, TRIG, WAIT_RISE, MEAS, GAP.
REQ-022 In IDLE, fire_measure with a nonzero ch_en SHALL latch ch_en and mode, clear err_measure, select the lowest enabled channel and enter TRIG on the next cycle.
REQ-023 fire_measure SHALL be ignored while busy, and in IDLE when ch_en is zero.
REQ-024 In TRIG, trig[ch] SHALL be high for exactly TRIG_US pluse_us ticks, then the FSM SHALL enter WAIT_RISE; all other trig bits SHALL be 0.
REQ-025 In WAIT_RISE, echo[ch] high SHALL enter MEAS with the width counter at 0; TIMEOUT_US ticks without a rise SHALL set err_measure[ch], emit dat_vld with dat_val all-ones, and enter GAP.
REQ-026 In MEAS, the counter SHALL increment on each pluse_us while echo[ch] is high.
REQ-027 In MEAS, echo[ch] low SHALL emit dat_vld with dat_val equal to the counter and enter GAP.
REQ-028 In MEAS, a counter reaching TIMEOUT_US SHALL set err_measure[ch], emit dat_val all-ones and enter GAP.
REQ-029 GAP SHALL last GAP_US ticks.
REQ-030 On GAP expiry, the FSM SHALL select the next higher enabled channel from the latched mask and enter TRIG.
REQ-031 If no higher enabled channel exists on GAP expiry, done_measure SHALL pulse.
REQ-032 After the done_measure pulse, mode 0 SHALL go to IDLE; mode 1 SHALL restart at the lowest enabled channel in TRIG with err_measure cleared, unless a stop is pending.
REQ-033 stop_measure SHALL set a pending flag and take effect only at sweep end (done_measure still pulses, then IDLE); in IDLE it SHALL be ignored.
REQ-034 fire_measure and stop_measure in the same IDLE cycle: fire SHALL win.
REQ-035 pluse_us coinciding with an echo fall SHALL not increment the counter.
REQ-036 Changes to ch_en while busy SHALL have no effect until the next accepted fire.
REQ-037 The data path SHALL have exactly one dat_vld per enabled channel per sweep, in ascending channel order.

Reset
REQ-038 On rst_n low, asynchronously: state IDLE, trig 0, busy 0, dat_vld 0, dat_ch 0, dat_val 0, err_measure 0, done_measure 0, all counters and the stop flag cleared; this applies mid-measurement too.
REQ-039 After rst_n deasserts, the first action SHALL require a new fire_measure.

Verification (CH_NUM=4, TRIG_US=10, TIMEOUT_US=100, GAP_US=20)
REQ-040 Stimulus: ch_en=4'b0101, mode 0, fire; echo0 high 37 us, echo2 high 5 us. Required response: trig0 high 10 us, then dat_vld ch0 val 37, then ch2 val 5, then one done_measure, busy low, err 0.
REQ-041 Stimulus: ch_en=4'b0010, echo1 never rises. Required response: dat_val 16'hFFFF, err_measure=4'b0010, done after 10+100+20 us.
REQ-042 Stimulus: echo3 held high 150 us. Required response: dat_val 16'hFFFF at the 100th tick, err bit3 set.
REQ-043 Stimulus: mode 1, ch_en=4'b0001, stop_measure mid-second sweep. Required response: second sweep completes, done pulses twice, then IDLE; a fire while busy is ignored.
REQ-044 Stimulus: rst_n low during MEAS. Required response: trig/busy go 0 immediately, no dat_vld.
REQ-045 Stimulus: fire with ch_en=0. Required response: no state change.
